// File: rtl/io_pkg.sv
// Shared definitions for the IO bus controller.
//   - page offsets (addr_low[9:4]) of the four memory-mapped devices
//   - one-hot bit index of each device in dev_sel
//   - FSM state encoding and the default acknowledge timeout
package io_pkg;

  localparam int NUM_DEV = 4;

  localparam logic [5:0] OFF_LED  = 6'h06;
  localparam logic [5:0] OFF_SW   = 6'h07;
  localparam logic [5:0] OFF_SEG7 = 6'h00;
  localparam logic [5:0] OFF_KEY  = 6'h01;

  localparam int DEV_LED  = 0;
  localparam int DEV_SW   = 1;
  localparam int DEV_SEG7 = 2;
  localparam int DEV_KEY  = 3;

  localparam logic [7:0] TIMEOUT_DEFAULT = 8'd200;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/io_addr_decode.sv
// Combinational IO page decoder.
//   addr_page : addr_low[9:4] of the CPU access
//   sel       : one-hot device select (LED, switch, seg7, keypad)
//   mapped    : high when addr_page hits one of the devices
module io_addr_decode
  import io_pkg::*;
(
  input  logic [5:0]         addr_page,
  output logic [NUM_DEV-1:0] sel,
  output logic               mapped
);

  always_comb begin
    sel = '0;
    unique case (addr_page)
      OFF_LED:  sel[DEV_LED]  = 1'b1;
      OFF_SW:   sel[DEV_SW]   = 1'b1;
      OFF_SEG7: sel[DEV_SEG7] = 1'b1;
      OFF_KEY:  sel[DEV_KEY]  = 1'b1;
      default:  sel = '0;
    endcase
    mapped = |sel;
  end

endmodule

// File: rtl/io_bus_ctrl.sv
// IO bus controller between the CPU pipeline and four slow devices.
// An IO load/store is held by the CPU while stall=1; the controller latches
// the access, raises dev_req until the selected device acknowledges (or the
// wait counter expires), then releases the pipeline for one DONE cycle.
//   clock, reset          : clock, asynchronous active-high reset
//   io_read, io_write     : CPU IO access decode
//   addr_low, wdata       : IO offset and store data
//   err_clr               : clears the sticky io_err flag
//   dev_ack, dev_rdata    : per-device acknowledge and read data
//   stall                 : pipeline freeze while an access is outstanding
//   rdata                 : zero-extended read result
//   dev_sel/req/we/addr/wdata : device-side request
//   io_err                : sticky error (unmapped, read+write, timeout)
module io_bus_ctrl
  import io_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [9:0]  addr_low,
  input  logic [31:0] wdata,
  input  logic        err_clr,
  input  logic [3:0]  dev_ack,
  input  logic [15:0] dev_rdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic [3:0]  dev_sel,
  output logic        dev_req,
  output logic        dev_we,
  output logic [3:0]  dev_addr,
  output logic [15:0] dev_wdata,
  output logic        io_err
);

  state_t      state, state_nxt;
  logic [3:0]  dec_sel;
  logic        mapped;
  logic [3:0]  sel_q;
  logic [7:0]  cnt;
  logic        access, conflict, start, bad_access, ack_hit, tmo;

  // Only the low half of the store data reaches the 16-bit device bus.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^wdata[31:16];

  io_addr_decode u_decode (
    .addr_page (addr_low[9:4]),
    .sel       (dec_sel),
    .mapped    (mapped)
  );

  assign access     = io_read | io_write;
  assign conflict   = io_read & io_write;
  assign start      = (state == ST_IDLE) & access & mapped;
  assign bad_access = (state == ST_IDLE) & access & ~mapped;
  // Acks from devices other than the latched one are ignored.
  assign ack_hit    = (state == ST_REQ) & |(dev_ack & sel_q);
  // Terminal count: the counter would reach TIMEOUT on this edge. Ack wins.
  assign tmo        = (state == ST_REQ) & ~ack_hit & (cnt == TIMEOUT - 8'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    dev_req   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          stall     = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        stall   = 1'b1;
        dev_req = 1'b1;
        if (ack_hit || tmo) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dev_sel = dev_req ? sel_q : 4'b0000;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_q     <= '0;
      dev_addr  <= '0;
      dev_we    <= 1'b0;
      dev_wdata <= '0;
      cnt       <= '0;
      rdata     <= '0;
      io_err    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (start) begin
            sel_q     <= dec_sel;
            dev_addr  <= addr_low[3:0];
            dev_we    <= io_write;     // read+write conflict executes as write
            dev_wdata <= wdata[15:0];
          end
          if (bad_access) rdata <= '0;
        end
        ST_REQ: begin
          cnt <= cnt + 8'd1;
          if (ack_hit) begin
            if (!dev_we) rdata <= {16'h0000, dev_rdata};
          end else if (tmo) begin
            rdata <= '0;
          end
        end
        default: ;
      endcase
      // Set has priority over a simultaneous clear.
      if (bad_access || (start && conflict) || tmo) io_err <= 1'b1;
      else if (err_clr)                             io_err <= 1'b0;
    end
  end

endmodule

// File: doc/io_bus_ctrl.md
IO_BUS_CTRL -- requirements
Module: io_bus_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, 8'd200, max cycles waited for device ack before forced completion.
REQ-002 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port io_read  in  1  CPU IO load decode, held stable while stall=1.
REQ-005 SHALL have port io_write  in  1  CPU IO store decode, held stable while stall=1.
REQ-006 SHALL have port addr_low  in  10  ALU result [9:0], IO offset within the 0xFFFFFC00 page.
REQ-007 SHALL have port wdata  in  32  store data from the register file.
REQ-008 SHALL have port err_clr  in  1  clears the sticky error flag.
REQ-009 SHALL have port dev_ack  in  4  per-device one-cycle acknowledge.
REQ-010 SHALL have port dev_rdata  in  16  read data from the selected device, valid with its ack.
REQ-011 SHALL have port stall  out  1  freezes PC/pipeline while an IO access is outstanding.
REQ-012 SHALL have port rdata  out  32  zero-extended IO read result to the writeback mux.
REQ-013 SHALL have port dev_sel  out  4  one-hot device select: 0=LED, 1=switch, 2=seg7, 3=keypad.
REQ-014 SHALL have ports dev_req (out 1), dev_we (out 1), dev_addr (out 4, addr_low[3:0]), dev_wdata (out 16, wdata[15:0]).
REQ-015 SHALL have port io_err  out  1  sticky: unmapped address, read+write conflict or timeout.

Function
REQ-016 SHALL decode addr_low[9:4]: 6'h06->LED, 6'h07->switch, 6'h00->seg7, 6'h01->keypad; all others unmapped.
REQ-017 SHALL implement FSM IDLE, REQ, DONE.
REQ-018 IDLE: on (io_read|io_write) with mapped address, latch sel/addr/we/wdata, go REQ.
REQ-019 SHALL drive stall combinationally = (IDLE & access & mapped) | REQ; stall=0 in DONE.
REQ-020 REQ: dev_req=1, dev_sel/dev_we/dev_addr/dev_wdata from latched values, all stable until exit.
REQ-021 REQ: dev_ack bit of the selected device -> latch dev_rdata (reads only), go DONE; ack bits of unselected devices ignored.
REQ-022 REQ: 8-bit wait counter cleared on entry, increments each cycle; when it reaches TIMEOUT with no ack -> rdata=0, io_err set, go DONE.
REQ-023 DONE: dev_req=0, rdata held, unconditional return to IDLE next cycle; no new access starts in DONE.
REQ-024 Unmapped access in IDLE: no stall, no dev_req, rdata=0, io_err set same edge.
REQ-025 io_read and io_write both high: executed as write, io_err set.
REQ-026 Writes SHALL leave rdata unchanged; reads SHALL present {16'h0, dev_rdata} from DONE until next read completes.
REQ-027 Ack on the same edge as the timeout terminal count: ack wins, io_err not set.
REQ-028 err_clr with simultaneous error event: set wins.
REQ-029 dev_sel SHALL be 4'b0000 whenever dev_req=0.
REQ-030 Latency: mapped access with ack in the first REQ cycle completes with stall high for exactly 2 cycles.

Reset
REQ-031 SHALL reset asynchronously to IDLE with stall=0, rdata=0, dev_req=0, dev_we=0, dev_sel=0, dev_addr=0, dev_wdata=0, io_err=0, counter=0.
REQ-032 Reset asserted in REQ SHALL drop dev_req immediately; a late ack after release SHALL be ignored in IDLE.

Structure
REQ-033 Device offsets, device index constants, FSM state encodings and TIMEOUT default SHALL live in the shared package io_pkg.
REQ-034 Address decode SHALL be one combinational sub-module io_addr_decode (addr_low -> dev_sel one-hot, mapped).

Verification
REQ-035 Read switch: io_read=1, addr_low=10'h070, dev_ack[1] on the 2nd REQ cycle with dev_rdata=16'hA5A5 -> stall high 3 cycles, rdata=32'h0000A5A5.
REQ-036 Write LED: io_write=1, addr_low=10'h060, wdata=32'h1234_00FF, immediate ack -> dev_we=1, dev_wdata=16'h00FF, dev_sel=4'b0001, stall 2 cycles.
REQ-037 Timeout: read seg7 (10'h000), no ack -> stall deasserts after TIMEOUT+1 cycles, rdata=0, io_err=1; err_clr -> io_err=0.
REQ-038 Unmapped 10'h3F0 read -> stall never asserted, rdata=0, io_err=1.
REQ-039 Reset asserted mid-REQ -> all outputs at reset values before the next edge; ack after release -> no state change.
REQ-040 Wrong-device ack: keypad access, dev_ack=4'b0001 -> stays in REQ; dev_ack=4'b1000 -> completes.
